// File: rtl/render_scheduler_if.sv
// Connections between the render scheduler, the black-clear and client renderers, and the
// VGA adapter. The scheduler takes the slave side; the environment drives the master side.
interface render_scheduler_if #(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic            frame_tick;
  logic            score_event;
  logic            blk_start;
  logic            blk_done;
  logic [XW-1:0]   blk_x;
  logic [YW-1:0]   blk_y;
  logic [2:0]      blk_col;
  logic [2:0]      cl_start;
  logic [2:0]      cl_done;
  logic [3*XW-1:0] cl_x;
  logic [3*YW-1:0] cl_y;
  logic [8:0]      cl_col;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [2:0]      vga_col;
  logic            vga_plot;
  logic            busy;
  logic            timeout_err;
  logic [7:0]      overrun_cnt;

  modport master (
    output frame_tick, score_event, blk_done, blk_x, blk_y, blk_col,
           cl_done, cl_x, cl_y, cl_col,
    input  blk_start, cl_start, vga_x, vga_y, vga_col, vga_plot,
           busy, timeout_err, overrun_cnt
  );

  modport slave (
    input  frame_tick, score_event, blk_done, blk_x, blk_y, blk_col,
           cl_done, cl_x, cl_y, cl_col,
    output blk_start, cl_start, vga_x, vga_y, vga_col, vga_plot,
           busy, timeout_err, overrun_cnt
  );
endinterface

// File: rtl/render_scheduler.sv
// Per-frame draw sequencer: optional black-clear, then ball, left paddle and right paddle,
// each owning the registered VGA write port until its done arrives or the watchdog expires.
module render_scheduler #(
  parameter int SCREEN_X = 640,
  parameter int SCREEN_Y = 480,
  parameter int TIMEOUT  = 400000
) (
  input  logic              clk,
  input  logic              resetn,
  render_scheduler_if.slave bus
);
  localparam int XW = $clog2(SCREEN_X) + 1;
  localparam int YW = $clog2(SCREEN_Y) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_BLK_START, S_BLK_WAIT, S_CL_START, S_CL_WAIT, S_NEXT
  } state_t;

  state_t        r_state;
  logic [1:0]    r_idx;
  logic          r_pend_blk;
  logic [TW-1:0] r_wd;
  logic          r_blk_start;
  logic [2:0]    r_cl_start;
  logic [XW-1:0] r_vga_x;
  logic [YW-1:0] r_vga_y;
  logic [2:0]    r_vga_col;
  logic          r_vga_plot;
  logic          r_busy;
  logic          r_timeout_err;
  logic [7:0]    r_overrun_cnt;

  logic          w_in_wait;
  logic          w_own_done;
  logic [XW-1:0] w_own_x;
  logic [YW-1:0] w_own_y;
  logic [2:0]    w_own_col;
  logic          w_wd_exp;

  assign w_wd_exp = (r_wd == TW'(TIMEOUT - 1));

  // Current owner of the pixel port; only meaningful in the two WAIT states.
  always_comb begin
    w_in_wait  = 1'b0;
    w_own_done = 1'b0;
    w_own_x    = '0;
    w_own_y    = '0;
    w_own_col  = '0;
    case (r_state)
      S_BLK_WAIT: begin
        w_in_wait  = 1'b1;
        w_own_done = bus.blk_done;
        w_own_x    = bus.blk_x;
        w_own_y    = bus.blk_y;
        w_own_col  = bus.blk_col;
      end
      S_CL_WAIT: begin
        w_in_wait  = 1'b1;
        w_own_done = bus.cl_done[r_idx];
        w_own_x    = bus.cl_x[r_idx*XW +: XW];
        w_own_y    = bus.cl_y[r_idx*YW +: YW];
        w_own_col  = bus.cl_col[r_idx*3 +: 3];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_idx         <= 2'd0;
      r_pend_blk    <= 1'b0;
      r_wd          <= '0;
      r_blk_start   <= 1'b0;
      r_cl_start    <= 3'b000;
      r_vga_x       <= '0;
      r_vga_y       <= '0;
      r_vga_col     <= 3'b000;
      r_vga_plot    <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_cnt <= 8'd0;
    end else begin
      r_blk_start <= 1'b0;
      r_cl_start  <= 3'b000;

      // The cycle that sees done already hands the port back.
      if (w_in_wait && !w_own_done) begin
        r_vga_x    <= w_own_x;
        r_vga_y    <= w_own_y;
        r_vga_col  <= w_own_col;
        r_vga_plot <= 1'b1;
      end else begin
        r_vga_x    <= '0;
        r_vga_y    <= '0;
        r_vga_col  <= 3'b000;
        r_vga_plot <= 1'b0;
      end

      if (bus.score_event)
        r_pend_blk <= 1'b1;
      if (bus.frame_tick && (r_state != S_IDLE) && (r_overrun_cnt != 8'hFF))
        r_overrun_cnt <= r_overrun_cnt + 8'd1;

      case (r_state)
        S_IDLE: begin
          if (bus.frame_tick) begin
            r_busy <= 1'b1;
            r_idx  <= 2'd0;
            // A score arriving with the tick is served in this same pass.
            if (r_pend_blk || bus.score_event) begin
              r_pend_blk  <= 1'b0;
              r_blk_start <= 1'b1;
              r_state     <= S_BLK_START;
            end else begin
              r_cl_start <= 3'b001;
              r_state    <= S_CL_START;
            end
          end
        end
        S_BLK_START: begin
          r_wd    <= '0;
          r_state <= S_BLK_WAIT;
        end
        S_BLK_WAIT: begin
          if (w_own_done || w_wd_exp) begin
            if (!w_own_done)
              r_timeout_err <= 1'b1;
            r_idx      <= 2'd0;
            r_cl_start <= 3'b001;
            r_state    <= S_CL_START;
          end else begin
            r_wd <= r_wd + TW'(1);
          end
        end
        S_CL_START: begin
          r_wd    <= '0;
          r_state <= S_CL_WAIT;
        end
        S_CL_WAIT: begin
          if (w_own_done || w_wd_exp) begin
            if (!w_own_done)
              r_timeout_err <= 1'b1;
            r_state <= S_NEXT;
          end else begin
            r_wd <= r_wd + TW'(1);
          end
        end
        S_NEXT: begin
          if (r_idx == 2'd2) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx      <= r_idx + 2'd1;
            r_cl_start <= 3'b010 << r_idx;
            r_state    <= S_CL_START;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.blk_start   = r_blk_start;
  assign bus.cl_start    = r_cl_start;
  assign bus.vga_x       = r_vga_x;
  assign bus.vga_y       = r_vga_y;
  assign bus.vga_col     = r_vga_col;
  assign bus.vga_plot    = r_vga_plot;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;
  assign bus.overrun_cnt = r_overrun_cnt;
endmodule

// File: tb/tb_render_scheduler.sv
// Scoreboard bench for render_scheduler: each pass pushes its expected start/plot events with
// their cycle numbers; a negedge monitor pops and compares every event the DUT presents.
module tb_render_scheduler;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int T  = 16;
  localparam logic [1:0] K_BLK  = 2'd0;
  localparam logic [1:0] K_CLS  = 2'd1;
  localparam logic [1:0] K_PLOT = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  exp_q[$];

  int         dly[3];
  int         cnt[3];
  bit         act[3];
  logic [2:0] dn;
  logic [2:0] stale;
  int         blk_dly;
  int         blk_cnt;
  bit         blk_act;
  logic       blk_stale;

  render_scheduler_if #(.XW(XW), .YW(YW)) rs_if ();

  render_scheduler #(.SCREEN_X(640), .SCREEN_Y(480), .TIMEOUT(T)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (rs_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act_v, exp_v);
    end else begin
      $display("ok   %s = %0d", nm, act_v);
    end
  endtask

  task automatic compare_ev(input logic [1:0] k, input logic [31:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got kind=%0d data=%h cycle=%0d, required none", k, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.data !== d || e.cyc != cyc) begin
        n_errors++;
        $display("FAIL scoreboard: got kind=%0d data=%h cycle=%0d, required kind=%0d data=%h cycle=%0d",
                 k, d, cyc, e.kind, e.data, e.cyc);
      end else begin
        $display("ok   event kind=%0d data=%h cycle=%0d", k, d, cyc);
      end
    end
  endtask

  // Monitor: one transaction per start pulse or plotted pixel.
  initial begin
    forever begin
      @(negedge clk);
      if (rs_if.vga_plot === 1'b1)
        compare_ev(K_PLOT, {8'd0, rs_if.vga_x, rs_if.vga_y, rs_if.vga_col});
      if (rs_if.blk_start === 1'b1)
        compare_ev(K_BLK, 32'd0);
      if (!$isunknown(rs_if.cl_start) && rs_if.cl_start != 3'b000)
        compare_ev(K_CLS, {29'd0, rs_if.cl_start});
    end
  end

  // Renderer models: x counts cycles since start; done after the configured delay (0 = never).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (!resetn) begin
          act[i] = 1'b0;
          cnt[i] = 0;
        end else if (rs_if.cl_start[i] === 1'b1) begin
          act[i] = 1'b1;
          cnt[i] = 0;
        end else if (act[i]) begin
          cnt[i]++;
        end
        dn[i] = act[i] && dly[i] != 0 && cnt[i] == dly[i];
        if (dn[i]) act[i] = 1'b0;
        rs_if.cl_x[i*XW +: XW] = XW'(cnt[i]);
        rs_if.cl_y[i*YW +: YW] = YW'(100 * (i + 1));
        rs_if.cl_col[i*3 +: 3] = 3'(i + 1);
      end
      rs_if.cl_done = dn | stale;
      if (!resetn) begin
        blk_act = 1'b0;
        blk_cnt = 0;
      end else if (rs_if.blk_start === 1'b1) begin
        blk_act = 1'b1;
        blk_cnt = 0;
      end else if (blk_act) begin
        blk_cnt++;
      end
      rs_if.blk_done = (blk_act && blk_dly != 0 && blk_cnt == blk_dly) || blk_stale;
      if (blk_act && blk_dly != 0 && blk_cnt == blk_dly) blk_act = 1'b0;
      rs_if.blk_x   = XW'(blk_cnt);
      rs_if.blk_y   = YW'(7);
      rs_if.blk_col = 3'd0;
    end
  end

  function automatic logic [31:0] pk(input int x, input int y, input int col);
    return {8'd0, 11'(x), 10'(y), 3'(col)};
  endfunction

  task automatic push_ev(input logic [1:0] k, input logic [31:0] d, input int c);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Start pulse at c, WAIT from c+1; returns the cycle after the last WAIT cycle.
  task automatic push_wait(input int c, input int d, input int y, input int col, output int nxt);
    int n_wait;
    int n_plot;
    n_wait = (d == 0) ? T : d;
    n_plot = (d == 0) ? T : d - 1;
    for (int j = 1; j <= n_plot; j++)
      push_ev(K_PLOT, pk(j, y, col), c + j + 1);
    nxt = c + n_wait + 1;
  endtask

  task automatic push_pass(input int t, input bit blk, input int bd,
                           input int d0, input int d1, input int d2, output int end_c);
    int c;
    int dd[3];
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    blk_dly = bd;
    for (int i = 0; i < 3; i++) dly[i] = dd[i];
    c = t + 1;
    if (blk) begin
      push_ev(K_BLK, 32'd0, c);
      push_wait(c, bd, 7, 0, c);
    end
    for (int i = 0; i < 3; i++) begin
      push_ev(K_CLS, 32'(1 << i), c);
      push_wait(c, dd[i], 100 * (i + 1), i + 1, c);
      c = c + 1;
    end
    end_c = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    rs_if.frame_tick = 1'b1;
    step();
    rs_if.frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input string nm, output int nb);
    bit done;
    nb = 0;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (rs_if.busy === 1'b0) done = 1'b1;
      else nb++;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_wait_idle: busy still high after 400 cycles, required low", nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_blk_start"},   rs_if.blk_start, 0);
    chk({p, "_cl_start"},    rs_if.cl_start, 0);
    chk({p, "_vga_x"},       rs_if.vga_x, 0);
    chk({p, "_vga_y"},       rs_if.vga_y, 0);
    chk({p, "_vga_col"},     rs_if.vga_col, 0);
    chk({p, "_vga_plot"},    rs_if.vga_plot, 0);
    chk({p, "_busy"},        rs_if.busy, 0);
    chk({p, "_timeout_err"}, rs_if.timeout_err, 0);
    chk({p, "_overrun_cnt"}, rs_if.overrun_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int t;
    int e;
    int nb;
    resetn = 1'b0;
    rs_if.frame_tick = 1'b0;
    rs_if.score_event = 1'b0;
    stale = 3'b000;
    blk_stale = 1'b0;
    blk_dly = 0;
    for (int i = 0; i < 3; i++) dly[i] = 5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    step();
    resetn = 1'b1;
    step();
    step();

    // Normal pass: three clients, done 5 cycles after each start.
    t = cyc;
    push_pass(t, 1'b0, 0, 5, 5, 5, e);
    tick();
    wait_idle("normal", nb);
    chk("normal_busy_cycles", nb, 21);
    chk("normal_queue_left", exp_q.size(), 0);

    // Score event, tick 10 cycles later: black-clear first.
    rs_if.score_event = 1'b1;
    step();
    rs_if.score_event = 1'b0;
    repeat (9) step();
    t = cyc;
    push_pass(t, 1'b1, 4, 3, 2, 6, e);
    tick();
    wait_idle("score", nb);
    chk("score_busy_cycles", nb, e - t - 1);
    chk("score_queue_left", exp_q.size(), 0);

    t = cyc;
    push_pass(t, 1'b0, 0, 5, 5, 5, e);
    tick();
    wait_idle("after_score", nb);
    chk("after_score_busy_cycles", nb, 21);
    chk("after_score_queue_left", exp_q.size(), 0);

    // Score and tick in the same cycle.
    t = cyc;
    push_pass(t, 1'b1, 2, 1, 1, 1, e);
    rs_if.score_event = 1'b1;
    tick();
    rs_if.score_event = 1'b0;
    wait_idle("same_cycle", nb);
    chk("same_cycle_busy_cycles", nb, 12);
    chk("same_cycle_queue_left", exp_q.size(), 0);

    t = cyc;
    push_pass(t, 1'b0, 0, 2, 2, 2, e);
    tick();
    wait_idle("after_same", nb);
    chk("after_same_busy_cycles", nb, 12);
    chk("after_same_queue_left", exp_q.size(), 0);

    // Timeout: client 1 never finishes.
    chk("pre_timeout_err", rs_if.timeout_err, 0);
    t = cyc;
    push_pass(t, 1'b0, 0, 5, 0, 5, e);
    tick();
    wait_idle("timeout", nb);
    chk("timeout_busy_cycles", nb, 32);
    chk("timeout_err", rs_if.timeout_err, 1);
    chk("timeout_queue_left", exp_q.size(), 0);

    // Overrun: tick held during every busy cycle of 15 passes (21 dropped ticks each).
    chk("pre_overrun_cnt", rs_if.overrun_cnt, 0);
    for (int p = 0; p < 15; p++) begin
      t = cyc;
      push_pass(t, 1'b0, 0, 5, 5, 5, e);
      rs_if.frame_tick = 1'b1;
      repeat (21) step();
      step();
      rs_if.frame_tick = 1'b0;
      chk("overrun_idle_gap_busy", rs_if.busy, 0);
      step();
      if (p == 11) chk("overrun_cnt_252", rs_if.overrun_cnt, 252);
    end
    chk("overrun_cnt_sat", rs_if.overrun_cnt, 255);
    chk("overrun_queue_left", exp_q.size(), 0);

    // Mid-pass reset during client 1 WAIT.
    for (int i = 0; i < 3; i++) dly[i] = 5;
    t = cyc;
    push_ev(K_CLS, 32'd1, t + 1);
    for (int j = 1; j <= 4; j++) push_ev(K_PLOT, pk(j, 100, 1), t + j + 2);
    push_ev(K_CLS, 32'd2, t + 8);
    push_ev(K_PLOT, pk(1, 200, 2), t + 10);
    push_ev(K_PLOT, pk(2, 200, 2), t + 11);
    tick();
    repeat (10) step();
    resetn = 1'b0;
    step();
    @(negedge clk);
    check_zero("midreset");
    step();
    resetn = 1'b1;
    step();
    stale = 3'b111;
    blk_stale = 1'b1;
    step();
    stale = 3'b000;
    blk_stale = 1'b0;
    repeat (4) step();
    chk("stale_done_busy", rs_if.busy, 0);
    chk("stale_done_cl_start", rs_if.cl_start, 0);
    chk("midreset_queue_left", exp_q.size(), 0);

    // Recovery pass.
    t = cyc;
    push_pass(t, 1'b0, 0, 5, 5, 5, e);
    tick();
    wait_idle("recovery", nb);
    chk("recovery_busy_cycles", nb, 21);
    chk("recovery_queue_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
